// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of mem_port_arbiter.
// The arbiter takes the slave modport; the pipeline/memory environment takes the master modport.
interface mem_port_arbiter_if #(
    parameter int N        = 32,
    parameter int MEM_ADDR = 8
);
    logic                if_req;
    logic [MEM_ADDR-1:0] if_addr;
    logic [N-1:0]        if_rdata;
    logic                if_valid;
    logic                if_stall;
    logic                dm_req;
    logic                dm_write;
    logic [1:0]          dm_size;
    logic [MEM_ADDR-1:0] dm_addr;
    logic [N-1:0]        dm_wdata;
    logic [N-1:0]        dm_rdata;
    logic                dm_valid;
    logic                dm_stall;
    logic                mem_en;
    logic                mem_we;
    logic [1:0]          mem_size;
    logic [MEM_ADDR-1:0] mem_addr;
    logic [N-1:0]        mem_wdata;
    logic [N-1:0]        mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_write, dm_size, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
               mem_en, mem_we, mem_size, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_write, dm_size, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
               mem_en, mem_we, mem_size, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (IF) and load/store (DM) stages.
// Fixed DM priority by default; define ARB_ROUND_ROBIN_EN to alternate when both requesters are eligible.
module mem_port_arbiter #(
    parameter int N        = 32,
    parameter int MEM_ADDR = 8,
    parameter int MEM_LAT  = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          if_elig;
    logic          dm_elig;
    logic          grant_dm;
    logic          grant_if;

    // A requester's own valid masks its still-high req in the completion cycle.
    assign if_elig = bus.if_req & ~bus.if_valid;
    assign dm_elig = bus.dm_req & ~bus.dm_valid;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;  // 0 = IF, 1 = DM
    assign grant_dm = dm_elig & (~if_elig | ~last_grant);
`else
    assign grant_dm = dm_elig;
`endif
    assign grant_if = if_elig & ~grant_dm;

    assign bus.if_stall = bus.if_req & ~bus.if_valid;
    assign bus.dm_stall = bus.dm_req & ~bus.dm_valid;

    // NOTE: every register here is sequential state, so all updates use non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.if_rdata  <= {N{1'b0}};
            bus.dm_rdata  <= {N{1'b0}};
            bus.if_valid  <= 1'b0;
            bus.dm_valid  <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_size  <= 2'b00;
            bus.mem_addr  <= {MEM_ADDR{1'b0}};
            bus.mem_wdata <= {N{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= 1'b0;
`endif
        end else begin
            bus.if_valid <= 1'b0;
            bus.dm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state         <= BUSY_DM;
                        cnt           <= CW'(MEM_LAT);
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= bus.dm_write;
                        bus.mem_size  <= bus.dm_size;
                        bus.mem_addr  <= bus.dm_addr;
                        bus.mem_wdata <= bus.dm_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant    <= 1'b1;
`endif
                    end else if (grant_if) begin
                        state         <= BUSY_IF;
                        cnt           <= CW'(MEM_LAT);
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_size  <= 2'b10;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= {N{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant    <= 1'b0;
`endif
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        // Stores leave dm_rdata holding the previous load.
                        if (state == BUSY_IF) begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_valid <= 1'b1;
                        end else begin
                            if (!bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
                            bus.dm_valid <= 1'b1;
                        end
                        state      <= IDLE;
                        bus.mem_en <= 1'b0;
                        bus.mem_we <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
